// File: rtl/secp256k1_pkg.sv
// secp256k1_pkg: field/point types, FSM state codes and a software Jacobian->affine model.
package secp256k1_pkg;
    typedef logic [255:0] fe_t;
    typedef struct packed { fe_t z; fe_t y; fe_t x; } jb_point_t;
    typedef struct packed { fe_t y; fe_t x; } af_point_t;

    localparam fe_t P         = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
    localparam fe_t P_MINUS_2 = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2D;

    // Consecutive ZI2..DONE codes let the final stage advance by incrementing.
    localparam logic [3:0] ST_IDLE    = 4'd0;
    localparam logic [3:0] ST_CHK     = 4'd1;
    localparam logic [3:0] ST_INV_SQR = 4'd2;
    localparam logic [3:0] ST_INV_MUL = 4'd3;
    localparam logic [3:0] ST_ZI2     = 4'd4;
    localparam logic [3:0] ST_AFX     = 4'd5;
    localparam logic [3:0] ST_ZI3     = 4'd6;
    localparam logic [3:0] ST_AFY     = 4'd7;
    localparam logic [3:0] ST_DONE    = 4'd8;

    function automatic fe_t fe_mul(fe_t a, fe_t b);
        return fe_t'((512'(a) * 512'(b)) % 512'(P));
    endfunction

    function automatic fe_t fe_inv(fe_t z);
        fe_t acc = z;
        for (int i = 254; i >= 0; i--) begin
            acc = fe_mul(acc, acc);
            if (P_MINUS_2[8'(i)]) acc = fe_mul(acc, z);
        end
        return acc;
    endfunction

    function automatic af_point_t jb_to_af(jb_point_t p);
        fe_t zi  = fe_inv(p.z);
        fe_t zi2 = fe_mul(zi, zi);
        return '{y: fe_mul(p.y, fe_mul(zi2, zi)), x: fe_mul(p.x, zi2)};
    endfunction
endpackage

// File: rtl/if_axi_stream.sv
// if_axi_stream: valid/ready stream carrying data plus a control tag.
interface if_axi_stream #(
    parameter int DAT_BYTS = 8,
    parameter int CTL_BITS = 8
);
    logic [DAT_BYTS*8-1:0] dat;
    logic [CTL_BITS-1:0]   ctl;
    logic                  val;
    logic                  rdy;
    modport source (output dat, ctl, val, input rdy);
    modport sink (input dat, ctl, val, output rdy);
endinterface

// File: rtl/secp256k1_fe_inv.sv
// secp256k1_fe_inv: Z^(p-2) by MSB-first square-and-multiply, one multiply outstanding.
module secp256k1_fe_inv
    import secp256k1_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  fe_t        z_i,
    output logic       done_o,
    output fe_t        inv_o,
    output logic       bad_o,
    output logic       req_val_o,
    input  logic       req_rdy_i,
    output fe_t        req_a_o,
    output fe_t        req_b_o,
    output logic [7:0] req_tag_o,
    input  logic       res_val_i,
    output logic       res_rdy_o,
    input  fe_t        res_dat_i,
    input  logic [7:0] res_tag_i
);
    fe_t        acc_q, z_q;
    logic [7:0] idx_q;
    logic       busy_q, mul_q, wait_q, done_q, res_ok;

    assign req_val_o = busy_q && !wait_q;
    assign req_a_o   = acc_q;
    assign req_b_o   = mul_q ? z_q : acc_q;
    assign req_tag_o = {4'd0, mul_q ? ST_INV_MUL : ST_INV_SQR};
    assign res_rdy_o = busy_q && wait_q;
    assign res_ok    = res_rdy_o && res_val_i;
    assign bad_o     = res_ok && res_tag_i != req_tag_o;
    assign done_o    = done_q;
    assign inv_o     = acc_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q  <= '0;
            z_q    <= '0;
            idx_q  <= '0;
            busy_q <= 1'b0;
            mul_q  <= 1'b0;
            wait_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start_i && !busy_q) begin
                busy_q <= 1'b1;
                acc_q  <= z_i;
                z_q    <= z_i;
                idx_q  <= 8'd254;
                mul_q  <= 1'b0;
                wait_q <= 1'b0;
            end
            if (req_val_o && req_rdy_i) wait_q <= 1'b1;
            if (res_ok) begin
                acc_q  <= res_dat_i;
                wait_q <= 1'b0;
                if (!mul_q && P_MINUS_2[idx_q]) begin
                    mul_q <= 1'b1;
                end else begin
                    mul_q <= 1'b0;
                    idx_q <= idx_q - 8'd1;
                    if (idx_q == 8'd0) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: rtl/secp256k1_jb_to_affine.sv
// secp256k1_jb_to_affine: Jacobian (X,Y,Z) -> affine (X/Z^2, Y/Z^3) through one shared mult port.
// SECP256K1_JB_AFFINE_Z1_BYPASS_EN: points with Z==1 are passed straight through.
module secp256k1_jb_to_affine
    import secp256k1_pkg::*;
#(
    parameter int CTL_BITS = 16
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  jb_point_t    i_p,
    input  logic         i_val,
    output logic         o_rdy,
    output af_point_t    o_p,
    output logic         o_err,
    output logic         o_val,
    input  logic         i_rdy,
    if_axi_stream.source o_mul_if,
    if_axi_stream.sink   i_mul_if
);
    jb_point_t  p_q;
    fe_t        t_q, inv, inv_a, inv_b, op_a, op_b, res;
    logic [3:0] state_q;
    logic [7:0] inv_tag;
    logic       run_q, err_q, wait_q, fin, res_ok, tag_bad, z_skip;
    logic       inv_start, inv_done, inv_bad, inv_req_val, inv_res_rdy;

`ifdef SECP256K1_JB_AFFINE_Z1_BYPASS_EN
    assign z_skip = p_q.z == fe_t'(0) || p_q.z == fe_t'(1);
`else
    assign z_skip = p_q.z == fe_t'(0);
`endif

    assign fin       = state_q inside {ST_ZI2, ST_AFX, ST_ZI3, ST_AFY};
    assign res       = i_mul_if.dat[255:0];
    assign res_ok    = fin && wait_q && i_mul_if.val;
    assign tag_bad   = i_mul_if.ctl[7:0] != {4'd0, state_q};
    assign inv_start = state_q == ST_CHK && !z_skip;
    assign op_a      = state_q == ST_AFX ? p_q.x : state_q == ST_ZI3 ? t_q : state_q == ST_AFY ? p_q.y : inv;
    assign op_b      = state_q inside {ST_ZI2, ST_ZI3} ? inv : t_q;

    // Final-stage products own the port outside the inversion; IDLE sinks stale results.
    assign o_mul_if.val = fin ? !wait_q : inv_req_val;
    assign o_mul_if.dat = fin ? {op_b, op_a} : {inv_b, inv_a};
    assign o_mul_if.ctl = CTL_BITS'(fin ? {4'd0, state_q} : inv_tag);
    assign i_mul_if.rdy = fin ? wait_q : state_q == ST_IDLE ? run_q : inv_res_rdy;

    assign o_rdy = run_q && state_q == ST_IDLE;
    assign o_val = state_q == ST_DONE;
    assign o_err = o_val && err_q;
    assign o_p   = o_val ? af_point_t'({p_q.y, p_q.x}) : '0;

    secp256k1_fe_inv u_inv (
        .clk_i     (i_clk),
        .rst_ni    (i_rst),
        .start_i   (inv_start),
        .z_i       (p_q.z),
        .done_o    (inv_done),
        .inv_o     (inv),
        .bad_o     (inv_bad),
        .req_val_o (inv_req_val),
        .req_rdy_i (o_mul_if.rdy),
        .req_a_o   (inv_a),
        .req_b_o   (inv_b),
        .req_tag_o (inv_tag),
        .res_val_i (i_mul_if.val),
        .res_rdy_o (inv_res_rdy),
        .res_dat_i (res),
        .res_tag_i (i_mul_if.ctl[7:0])
    );

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= ST_IDLE;
            p_q     <= '0;
            t_q     <= '0;
            run_q   <= 1'b0;
            err_q   <= 1'b0;
            wait_q  <= 1'b0;
        end else begin
            run_q <= 1'b1;
            if (inv_bad) err_q <= 1'b1;
            if (fin && !wait_q && o_mul_if.rdy) wait_q <= 1'b1;
            if (res_ok) begin
                wait_q  <= 1'b0;
                state_q <= state_q + 4'd1;
                if (tag_bad) err_q <= 1'b1;
                if (state_q == ST_AFX) p_q.x <= res;
                else if (state_q == ST_AFY) p_q.y <= res;
                else t_q <= res;
            end
            if (o_rdy && i_val) begin
                p_q     <= i_p;
                err_q   <= 1'b0;
                state_q <= ST_CHK;
            end
            if (state_q == ST_CHK) begin
                state_q <= z_skip ? ST_DONE : ST_INV_SQR;
                if (p_q.z == fe_t'(0)) begin
                    p_q.x <= '0;
                    p_q.y <= '0;
                    err_q <= 1'b1;
                end
            end
            if (state_q == ST_INV_SQR && inv_done) state_q <= ST_ZI2;
            if (o_val && i_rdy) begin
                state_q <= ST_IDLE;
                err_q   <= 1'b0;
            end
        end
    end
endmodule
